// File: rtl/snake_body_updater.sv
`default_nettype none
// ============================================================================
// Module   : snake_body_updater
// Purpose  : Advances a snake one grid cell per move_tick, shifting its tail
//            list through an external memory and wrapping at the grid edges.
// Revision : 1.0 - initial release
// ============================================================================
module snake_body_updater #(
    parameter int          GRID_W    = 40,
    parameter int          GRID_H    = 30,
    parameter logic [11:0] START_POS = 12'h28F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        move_tick,
    input  logic        grow,
    input  logic [1:0]  dir_in,
    input  logic [11:0] mem_rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [6:0]  mem_addr,
    output logic [11:0] mem_wdata,
    output logic [11:0] head_pos,
    output logic [6:0]  num_tails,
    output logic        busy,
    output logic        done
);

    localparam logic [6:0] c_MAX_TAILS = 7'd127;
    localparam logic [1:0] c_DIR_UP    = 2'b00;
    localparam logic [1:0] c_DIR_RIGHT = 2'b01;
    localparam logic [1:0] c_DIR_DOWN  = 2'b10;
    localparam logic [1:0] c_DIR_LEFT  = 2'b11;
    localparam logic [5:0] c_X_MAX     = 6'(GRID_W - 1);
    localparam logic [5:0] c_Y_MAX     = 6'(GRID_H - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_HEAD = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [6:0]  r_idx;
    logic [6:0]  r_len;
    logic [6:0]  r_num;
    logic [1:0]  r_dir;
    logic [11:0] r_head;
    logic        r_busy;
    logic        r_done;

    logic [6:0]  w_len;
    logic        w_reverse;
    logic [5:0]  w_x;
    logic [5:0]  w_y;
    logic [5:0]  w_x_next;
    logic [5:0]  w_y_next;

    // A growing move at the tail cap degrades to a plain move
    assign w_len     = (grow && (r_num != c_MAX_TAILS)) ? r_num + 7'd1 : r_num;
    assign w_reverse = (dir_in == (r_dir ^ 2'b10)) && (r_num != 7'd0);

    assign w_x = r_head[11:6];
    assign w_y = r_head[5:0];

    always_comb begin
        w_x_next = w_x;
        w_y_next = w_y;
        case (r_dir)
            c_DIR_UP:    w_y_next = (w_y == 6'd0)    ? c_Y_MAX : w_y - 6'd1;
            c_DIR_RIGHT: w_x_next = (w_x == c_X_MAX) ? 6'd0    : w_x + 6'd1;
            c_DIR_DOWN:  w_y_next = (w_y == c_Y_MAX) ? 6'd0    : w_y + 6'd1;
            c_DIR_LEFT:  w_x_next = (w_x == 6'd0)    ? c_X_MAX : w_x - 6'd1;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 7'd0;
        mem_wdata    = 12'd0;
        case (r_state)
            S_IDLE: begin
                if (move_tick) begin
                    if (w_len >= 7'd2)      w_next_state = S_RD;
                    else if (w_len == 7'd1) w_next_state = S_HEAD;
                    else                    w_next_state = S_DONE;
                end
            end
            S_RD: begin
                mem_rd       = 1'b1;
                mem_addr     = r_idx - 7'd1;
                w_next_state = S_WR;
            end
            S_WR: begin
                // Read data from the preceding RD cycle moves one slot back
                mem_wr       = 1'b1;
                mem_addr     = r_idx;
                mem_wdata    = mem_rdata;
                w_next_state = (r_idx >= 7'd2) ? S_RD : S_HEAD;
            end
            S_HEAD: begin
                mem_wr       = 1'b1;
                mem_wdata    = r_head;
                w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_head  <= START_POS;
            r_num   <= 7'd0;
            r_dir   <= c_DIR_RIGHT;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= 7'd0;
            r_len   <= 7'd0;
        end else begin
            r_state <= w_next_state;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (move_tick) begin
                        r_len  <= w_len;
                        r_idx  <= w_len - 7'd1;
                        r_busy <= 1'b1;
                        if (!w_reverse) r_dir <= dir_in;
                    end
                end
                S_WR: r_idx <= r_idx - 7'd1;
                S_DONE: begin
                    r_head <= {w_x_next, w_y_next};
                    r_num  <= r_len;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign head_pos  = r_head;
    assign num_tails = r_num;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_snake_body_updater.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_body_updater
// Purpose  : Self-checking bench with a tail-memory model and an event
//            scoreboard for snake_body_updater.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_body_updater;

    localparam int          GRID_W    = 40;
    localparam int          GRID_H    = 30;
    localparam logic [11:0] START_POS = 12'h28F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        move_tick = 1'b0;
    logic        grow = 1'b0;
    logic [1:0]  dir_in = 2'b01;
    logic [11:0] mem_rdata = 12'd0;
    logic        mem_rd;
    logic        mem_wr;
    logic [6:0]  mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] head_pos;
    logic [6:0]  num_tails;
    logic        busy;
    logic        done;

    snake_body_updater #(
        .GRID_W    (GRID_W),
        .GRID_H    (GRID_H),
        .START_POS (START_POS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .move_tick (move_tick),
        .grow      (grow),
        .dir_in    (dir_in),
        .mem_rdata (mem_rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .head_pos  (head_pos),
        .num_tails (num_tails),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Tail memory: one-cycle read latency
    logic [11:0] mem [128];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // Reference model and scoreboard of expected strobes {rd, wr, addr, data}
    logic [20:0] exp_q[$];
    logic [11:0] m_head;
    int          m_num;
    logic [1:0]  m_dir;
    logic [11:0] m_tail [128];
    bit          mon_off = 1'b0;
    bit          saw_wr127 = 1'b0;

    always @(negedge clk) begin
        if (!mon_off && (mem_rd || mem_wr)) begin
            logic [20:0] ev;
            ev = {mem_rd, mem_wr, mem_addr, mem_wdata};
            check_val("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
            if (mem_wr && mem_addr == 7'd127) saw_wr127 = 1'b1;
            if (exp_q.size() == 0) check_val("unexpected_strobe", 32'(ev), 32'd0);
            else check_val("strobe_event", 32'(ev), 32'(exp_q.pop_front()));
        end
    end

    task automatic model_reset();
        m_head = START_POS;
        m_num  = 0;
        m_dir  = 2'b01;
        exp_q.delete();
    endtask

    task automatic model_move(input bit g, input bit [1:0] d, output int len);
        int x;
        int y;
        if (!(m_num > 0 && d == (m_dir ^ 2'b10))) m_dir = d;
        len = (g && m_num < 127) ? m_num + 1 : m_num;
        for (int i = len - 1; i >= 1; i--) begin
            exp_q.push_back({1'b1, 1'b0, 7'(i - 1), 12'h000});
            exp_q.push_back({1'b0, 1'b1, 7'(i), m_tail[i-1]});
        end
        if (len >= 1) exp_q.push_back({1'b0, 1'b1, 7'd0, m_head});
        for (int i = len - 1; i >= 1; i--) m_tail[i] = m_tail[i-1];
        if (len >= 1) m_tail[0] = m_head;
        x = int'(m_head[11:6]);
        y = int'(m_head[5:0]);
        case (m_dir)
            2'b00: y = (y + GRID_H - 1) % GRID_H;
            2'b01: x = (x + 1) % GRID_W;
            2'b10: y = (y + 1) % GRID_H;
            default: x = (x + GRID_W - 1) % GRID_W;
        endcase
        m_head = {6'(x), 6'(y)};
        m_num  = len;
    endtask

    // Called at a negedge; returns at a negedge with the DUT idle
    task automatic do_move(input bit g, input bit [1:0] d, input bit extra);
        int len;
        int cyc;
        model_move(g, d, len);
        move_tick = 1'b1;
        grow      = g;
        dir_in    = d;
        @(negedge clk);
        move_tick = 1'b0;
        grow      = 1'b0;
        check_val("busy_after_tick", 32'(busy), 32'd1);
        cyc = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (extra && cyc == 2) begin
                move_tick = 1'b1;
                grow      = 1'b1;
            end else begin
                move_tick = 1'b0;
                grow      = 1'b0;
            end
        end
        move_tick = 1'b0;
        grow      = 1'b0;
        check_val("latency", 32'(cyc), 32'((len >= 1) ? 2 * len + 1 : 2));
        check_val("head_pos", 32'(head_pos), 32'(m_head));
        check_val("num_tails", 32'(num_tails), 32'(m_num));
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check_val("done_one_cycle", 32'(done), 32'd0);
        check_val("busy_cleared", 32'(busy), 32'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_head"}, 32'(head_pos), 32'(START_POS));
        check_val({tag, "_num"}, 32'(num_tails), 32'd0);
        check_val({tag, "_busy_done"}, 32'({busy, done}), 32'd0);
        check_val({tag, "_strobes"}, 32'({mem_rd, mem_wr, mem_addr, mem_wdata}), 32'd0);
    endtask

    initial begin
        int cyc;
        logic [5:0] x0;

        @(negedge clk);
        apply_reset();
        check_reset_state("reset");

        // Plain move from reset, then a first growth
        do_move(1'b0, 2'b01, 1'b0);
        check_val("first_move_head", 32'(head_pos), 32'h2CF);
        apply_reset();
        do_move(1'b1, 2'b01, 1'b0);
        check_val("first_grow_tail", 32'(mem[0]), 32'h28F);

        // Reversal ignored, dropped tick while busy, then a length-3 shift
        do_move(1'b1, 2'b01, 1'b0);
        x0 = head_pos[11:6];
        do_move(1'b0, 2'b11, 1'b0);
        check_val("reverse_ignored_x", 32'(head_pos[11:6]), 32'(x0 + 6'd1));
        do_move(1'b0, 2'b01, 1'b1);
        repeat (3) @(negedge clk);
        check_val("dropped_tick_idle", 32'({busy, num_tails}), 32'd2);
        do_move(1'b1, 2'b00, 1'b0);
        do_move(1'b0, 2'b00, 1'b0);

        // Reset while a shift write is in flight
        mon_off   = 1'b1;
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        cyc = 0;
        while (!(mem_wr && mem_addr != 7'd0) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_val("reached_wr", 32'(cyc < 50), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midmove_reset");
        reset = 1'b0;
        model_reset();
        mon_off = 1'b0;
        @(negedge clk);

        // Edge wrap in x then y
        for (int k = 0; k < 29; k++) do_move(1'b0, 2'b01, 1'b0);
        check_val("x_at_max", 32'(head_pos[11:6]), 32'd39);
        do_move(1'b0, 2'b01, 1'b0);
        check_val("x_wrapped", 32'(head_pos[11:6]), 32'd0);
        for (int k = 0; k < 15; k++) do_move(1'b0, 2'b00, 1'b0);
        check_val("y_at_zero", 32'(head_pos[5:0]), 32'd0);
        do_move(1'b0, 2'b00, 1'b0);
        check_val("y_wrapped", 32'(head_pos[5:0]), 32'd29);

        // Fill to the tail cap, then request one more growth
        apply_reset();
        while (m_num < 127) do_move(1'b1, 2'(m_num % 2), 1'b0);
        check_val("tails_full", 32'(num_tails), 32'd127);
        saw_wr127 = 1'b0;
        do_move(1'b1, 2'b01, 1'b0);
        check_val("cap_num_tails", 32'(num_tails), 32'd127);
        check_val("no_write_127", 32'(saw_wr127), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
